// File: rtl/alu_pipe_top_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_top_if
// Brief    : Issue and writeback bundle between the issue stage, the ALU
//            pipeline and the writeback arbiter.
// Revision : 1.0
// ============================================================================
interface alu_pipe_top_if #(
    parameter int DATA = 32,
    parameter int ROB  = 5,
    parameter int RD   = 6
);
    logic            issue_e_;
    logic [3:0]      issue_op;
    logic            issue_trap;
    logic [ROB-1:0]  issue_rob_id;
    logic [RD-1:0]   issue_rd;
    logic [DATA-1:0] data1;
    logic [DATA-1:0] data2;
    logic            issue_ready;
    logic            wb_req_;
    logic            wb_ack_;
    logic [ROB-1:0]  wb_rob_id;
    logic [RD-1:0]   wb_rd;
    logic [DATA-1:0] wb_data;
    logic            wb_exp_;

    modport master (
        output issue_e_, issue_op, issue_trap, issue_rob_id, issue_rd,
               data1, data2, wb_ack_,
        input  issue_ready, wb_req_, wb_rob_id, wb_rd, wb_data, wb_exp_
    );

    modport slave (
        input  issue_e_, issue_op, issue_trap, issue_rob_id, issue_rd,
               data1, data2, wb_ack_,
        output issue_ready, wb_req_, wb_rob_id, wb_rd, wb_data, wb_exp_
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_top.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_top
// Brief    : Credit-gated pipelined integer ALU with a tagged writeback queue
//            drained through a req/ack handshake.
// Revision : 1.0
// ============================================================================
module alu_pipe_top #(
    parameter int DATA      = 32,
    parameter int ROB_DEPTH = 32,
    parameter int RD        = 6,
    parameter int STAGES    = 2,
    parameter int WBQ_DEPTH = 4,
    localparam int ROB      = $clog2(ROB_DEPTH),
    localparam int CNT      = $clog2(WBQ_DEPTH + 1)
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           flush_,
    alu_pipe_top_if.slave       bus,
    output logic [CNT-1:0]      inflight,
    output logic                busy
);
    localparam int SH = $clog2(DATA);
    localparam int PW = $clog2(WBQ_DEPTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_SLL  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_PASS = 4'd10;

    logic [CNT-1:0]  r_inflight;
    logic [CNT-1:0]  r_qcount;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [DATA-1:0] r_q_data [WBQ_DEPTH];
    logic [ROB-1:0]  r_q_rob  [WBQ_DEPTH];
    logic [RD-1:0]   r_q_rd   [WBQ_DEPTH];
    logic            r_q_exp  [WBQ_DEPTH];

    logic            w_ready;
    logic            w_fire;
    logic            w_pop;
    logic            w_q_empty;
    logic [DATA-1:0] w_sum;
    logic [DATA-1:0] w_diff;
    logic [SH-1:0]   w_sh;
    logic [DATA-1:0] w_res;
    logic            w_exp;
    logic            w_wr_v;
    logic [DATA-1:0] w_wr_data;
    logic [ROB-1:0]  w_wr_rob;
    logic [RD-1:0]   w_wr_rd;
    logic            w_wr_exp;
    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_rd_nxt;

    // Credits come from registered occupancy only; a same-cycle pop never frees one early.
    assign w_ready   = (r_inflight < CNT'(WBQ_DEPTH));
    assign w_fire    = ~bus.issue_e_ & w_ready;
    assign w_q_empty = (r_qcount == '0);
    assign w_pop     = ~w_q_empty & ~bus.wb_ack_;

    assign w_sum  = bus.data1 + bus.data2;
    assign w_diff = bus.data1 - bus.data2;
    assign w_sh   = bus.data2[SH-1:0];

    always_comb begin
        w_res = '0;
        w_exp = 1'b0;
        case (bus.issue_op)
            c_OP_ADD: begin
                w_res = w_sum;
                w_exp = bus.issue_trap & (bus.data1[DATA-1] == bus.data2[DATA-1])
                        & (w_sum[DATA-1] != bus.data1[DATA-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_exp = bus.issue_trap & (bus.data1[DATA-1] != bus.data2[DATA-1])
                        & (w_diff[DATA-1] != bus.data1[DATA-1]);
            end
            c_OP_AND:  w_res = bus.data1 & bus.data2;
            c_OP_OR:   w_res = bus.data1 | bus.data2;
            c_OP_XOR:  w_res = bus.data1 ^ bus.data2;
            c_OP_SLT:  w_res = {{(DATA-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
            c_OP_SLTU: w_res = {{(DATA-1){1'b0}}, (bus.data1 < bus.data2)};
            c_OP_SLL:  w_res = bus.data1 << w_sh;
            c_OP_SRL:  w_res = bus.data1 >> w_sh;
            c_OP_SRA:  w_res = DATA'($signed(bus.data1) >>> w_sh);
            c_OP_PASS: w_res = bus.data2;
            default:   w_exp = 1'b1;
        endcase
    end

    generate
        if (STAGES == 1) begin : g_direct
            // Single-cycle latency: the issue edge itself is the queue write.
            assign w_wr_v    = w_fire;
            assign w_wr_data = w_res;
            assign w_wr_rob  = bus.issue_rob_id;
            assign w_wr_rd   = bus.issue_rd;
            assign w_wr_exp  = w_exp;
        end else begin : g_pipe
            logic [STAGES-2:0] r_v;
            logic [DATA-1:0]   r_d   [STAGES-1];
            logic [ROB-1:0]    r_rob [STAGES-1];
            logic [RD-1:0]     r_rd  [STAGES-1];
            logic [STAGES-2:0] r_e;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_v <= '0;
                    r_e <= '0;
                    for (int i = 0; i < STAGES - 1; i++) begin
                        r_d[i]   <= '0;
                        r_rob[i] <= '0;
                        r_rd[i]  <= '0;
                    end
                end else begin
                    r_d[0]   <= w_res;
                    r_rob[0] <= bus.issue_rob_id;
                    r_rd[0]  <= bus.issue_rd;
                    r_e[0]   <= w_exp;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        r_d[i]   <= r_d[i-1];
                        r_rob[i] <= r_rob[i-1];
                        r_rd[i]  <= r_rd[i-1];
                        r_e[i]   <= r_e[i-1];
                    end
                    if (!flush_) begin
                        r_v <= '0;
                    end else begin
                        r_v[0] <= w_fire;
                        for (int i = 1; i < STAGES - 1; i++) begin
                            r_v[i] <= r_v[i-1];
                        end
                    end
                end
            end

            assign w_wr_v    = r_v[STAGES-2];
            assign w_wr_data = r_d[STAGES-2];
            assign w_wr_rob  = r_rob[STAGES-2];
            assign w_wr_rd   = r_rd[STAGES-2];
            assign w_wr_exp  = r_e[STAGES-2];
        end
    endgenerate

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_nxt = (r_wr_ptr == PW'(WBQ_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == PW'(WBQ_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_qcount   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < WBQ_DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_rob[i]  <= '0;
                r_q_rd[i]   <= '0;
                r_q_exp[i]  <= 1'b0;
            end
        end else if (!flush_) begin
            r_inflight <= '0;
            r_qcount   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_wr_v) begin
                r_q_data[r_wr_ptr] <= w_wr_data;
                r_q_rob[r_wr_ptr]  <= w_wr_rob;
                r_q_rd[r_wr_ptr]   <= w_wr_rd;
                r_q_exp[r_wr_ptr]  <= w_wr_exp;
                r_wr_ptr           <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            r_qcount   <= r_qcount + CNT'(w_wr_v) - CNT'(w_pop);
            r_inflight <= r_inflight + CNT'(w_fire) - CNT'(w_pop);
        end
    end

    assign bus.issue_ready = w_ready;
    assign bus.wb_req_     = w_q_empty;
    assign bus.wb_data     = r_q_data[r_rd_ptr];
    assign bus.wb_rob_id   = r_q_rob[r_rd_ptr];
    assign bus.wb_rd       = r_q_rd[r_rd_ptr];
    assign bus.wb_exp_     = ~(r_q_exp[r_rd_ptr] & ~w_q_empty);
    assign inflight        = r_inflight;
    assign busy            = (r_inflight != '0);
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_top
// Brief    : Table-driven and scoreboard-checked bench for alu_pipe_top.
// Revision : 1.0
// ============================================================================
module tb_alu_pipe_top;
    localparam int DATA   = 32;
    localparam int ROB    = 5;
    localparam int RD     = 6;
    localparam int STAGES = 2;
    localparam int WBQ    = 4;
    localparam int CNT    = 3;

    typedef struct {
        logic [3:0]  op;
        logic        trap;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
        logic        exp;
    } vec_t;

    typedef struct {
        int          t;
        logic [4:0]  rob;
        logic [5:0]  rd;
        logic [31:0] data;
        logic        exp;
    } sb_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           flush_ = 1'b1;
    logic [CNT-1:0] inflight;
    logic           busy;

    alu_pipe_top_if #(.DATA(DATA), .ROB(ROB), .RD(RD)) bus ();

    alu_pipe_top #(
        .DATA(DATA), .ROB_DEPTH(32), .RD(RD), .STAGES(STAGES), .WBQ_DEPTH(WBQ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_(flush_),
        .bus(bus),
        .inflight(inflight),
        .busy(busy)
    );

    always #5 clk = ~clk;

    sb_t  sb[$];
    vec_t vt[17];
    vec_t nv;
    int   m_inflight = 0;
    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc_n);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic trap, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] res, input logic exp);
        vec_t v;
        v.op = op; v.trap = trap; v.d1 = d1; v.d2 = d2; v.res = res; v.exp = exp;
        return v;
    endfunction

    function automatic bit head_visible();
        return (sb.size() > 0) && (sb[0].t + STAGES <= cyc_n);
    endfunction

    // One clock cycle: check outputs against the model mid-cycle, drive, then advance the model.
    task automatic cycle(input logic iss, input vec_t v, input logic [4:0] rob, input logic [5:0] rd,
                         input logic ack, input logic fl);
        bit  hv;
        bit  acc;
        sb_t e;
        @(negedge clk);
        hv = head_visible();
        chk("issue_ready", {31'd0, bus.issue_ready}, {31'd0, m_inflight < WBQ});
        chk("inflight", {29'd0, inflight}, m_inflight);
        chk("busy", {31'd0, busy}, {31'd0, m_inflight != 0});
        chk("wb_req_", {31'd0, bus.wb_req_}, {31'd0, !hv});
        if (hv) begin
            chk("wb_data", bus.wb_data, sb[0].data);
            chk("wb_rob_id", {27'd0, bus.wb_rob_id}, {27'd0, sb[0].rob});
            chk("wb_rd", {26'd0, bus.wb_rd}, {26'd0, sb[0].rd});
            chk("wb_exp_", {31'd0, bus.wb_exp_}, {31'd0, !sb[0].exp});
        end
        bus.issue_e_     = !iss;
        bus.issue_op     = v.op;
        bus.issue_trap   = v.trap;
        bus.data1        = v.d1;
        bus.data2        = v.d2;
        bus.issue_rob_id = rob;
        bus.issue_rd     = rd;
        bus.wb_ack_      = !ack;
        flush_           = !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_inflight = 0;
        end else begin
            acc = iss && (m_inflight < WBQ);
            if (hv && ack) begin
                void'(sb.pop_front());
                m_inflight--;
            end
            if (acc) begin
                e.t = cyc_n; e.rob = rob; e.rd = rd; e.data = v.res; e.exp = v.exp;
                sb.push_back(e);
                m_inflight++;
            end
        end
        cyc_n++;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) cycle(1'b0, nv, 5'd0, 6'd0, ack, 1'b0);
    endtask

    task automatic pass_op(input logic [31:0] val, input logic [4:0] rob, input logic ack);
        cycle(1'b1, mkv(4'd10, 1'b0, 32'h0, val, val, 1'b0), rob, 6'(rob), ack, 1'b0);
    endtask

    initial begin
        nv = mkv(4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        vt[0]  = mkv(4'd0,  1'b0, 32'd5,        32'd7,        32'd12,       1'b0);
        vt[1]  = mkv(4'd9,  1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0);
        vt[2]  = mkv(4'd0,  1'b1, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1);
        vt[3]  = mkv(4'd0,  1'b0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0);
        vt[4]  = mkv(4'd12, 1'b0, 32'd5,        32'd6,        32'h0,        1'b1);
        vt[5]  = mkv(4'd1,  1'b1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1);
        vt[6]  = mkv(4'd1,  1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0);
        vt[7]  = mkv(4'd2,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        vt[8]  = mkv(4'd3,  1'b0, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0);
        vt[9]  = mkv(4'd4,  1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0);
        vt[10] = mkv(4'd5,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0);
        vt[11] = mkv(4'd6,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0);
        vt[12] = mkv(4'd7,  1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0);
        vt[13] = mkv(4'd8,  1'b0, 32'h80000000, 32'h24,       32'h08000000, 1'b0);
        vt[14] = mkv(4'd10, 1'b0, 32'd1,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        vt[15] = mkv(4'd15, 1'b0, 32'd3,        32'd4,        32'h0,        1'b1);
        vt[16] = mkv(4'd0,  1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0);

        bus.issue_e_ = 1'b1; bus.issue_op = 4'd0; bus.issue_trap = 1'b0;
        bus.data1 = '0; bus.data2 = '0; bus.issue_rob_id = '0; bus.issue_rd = '0;
        bus.wb_ack_ = 1'b1;

        #2;
        chk("rst_wb_req_", {31'd0, bus.wb_req_}, 32'd1);
        chk("rst_wb_exp_", {31'd0, bus.wb_exp_}, 32'd1);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", {26'd0, bus.wb_rd}, 32'd0);
        chk("rst_wb_rob_id", {27'd0, bus.wb_rob_id}, 32'd0);
        chk("rst_inflight", {29'd0, inflight}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        #10 reset = 1'b0;

        // Operation table, arbiter acking continuously.
        for (int i = 0; i < 17; i++) cycle(1'b1, vt[i], 5'(9 + i), 6'(3 + i), 1'b1, 1'b0);
        idle(4, 1'b1);

        // Backpressure: six issue attempts into a four-credit unit.
        for (int i = 0; i < 6; i++) pass_op(32'h100 + i, 5'(i), 1'b0);
        #1;
        chk("bp_inflight", {29'd0, inflight}, 32'd4);
        chk("bp_ready", {31'd0, bus.issue_ready}, 32'd0);
        idle(1, 1'b1);
        #1;
        chk("bp_ready_after_pop", {31'd0, bus.issue_ready}, 32'd1);
        idle(1, 1'b0);
        idle(5, 1'b1);

        // Simultaneous issue, queue write and pop at inflight=3.
        for (int i = 0; i < 3; i++) pass_op(32'h200 + i, 5'(20 + i), 1'b0);
        pass_op(32'h203, 5'd23, 1'b1);
        #1;
        chk("sim_inflight", {29'd0, inflight}, 32'd3);
        idle(6, 1'b1);

        // Flush with three queued and one in the pipeline, plus same-cycle issue and ack.
        for (int i = 0; i < 4; i++) pass_op(32'h300 + i, 5'(i), 1'b0);
        cycle(1'b1, mkv(4'd10, 1'b0, 32'h0, 32'h3FF, 32'h3FF, 1'b0), 5'd7, 6'd7, 1'b1, 1'b1);
        #1;
        chk("flush_wb_req_", {31'd0, bus.wb_req_}, 32'd1);
        chk("flush_inflight", {29'd0, inflight}, 32'd0);
        idle(5, 1'b1);

        // Asynchronous reset with entries queued.
        pass_op(32'h400, 5'd1, 1'b0);
        pass_op(32'h401, 5'd2, 1'b0);
        idle(3, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_wb_req_", {31'd0, bus.wb_req_}, 32'd1);
        chk("arst_wb_exp_", {31'd0, bus.wb_exp_}, 32'd1);
        chk("arst_wb_data", bus.wb_data, 32'd0);
        chk("arst_wb_rob_id", {27'd0, bus.wb_rob_id}, 32'd0);
        chk("arst_inflight", {29'd0, inflight}, 32'd0);
        chk("arst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        #1 reset = 1'b0;
        sb.delete();
        m_inflight = 0;
        cycle(1'b1, vt[0], 5'd9, 6'd3, 1'b1, 1'b0);
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_pipe_top.md
# alu_pipe_top

Parametrised, pipelined integer execution unit for the out-of-order backend. It accepts one ALU operation per cycle from the issue stage and computes it over `STAGES` pipeline cycles. Results go into a `WBQ_DEPTH`-entry writeback queue, tagged with ROB id and destination register, and drain through a req/ack handshake to the writeback arbiter. Issue is credit-gated, so the pipeline never stalls, and a flush discards every in-flight and queued result.

## Interface
Parameters:
- `DATA`, 32, operand/result width
- `ROB_DEPTH`, 32, ROB entries; `ROB` = $clog2(ROB_DEPTH)
- `RD`, 6, destination register tag width
- `STAGES`, 2, issue-to-queue latency in cycles, legal 1..4
- `WBQ_DEPTH`, 4, writeback queue entries, legal 2..16; `CNT` = $clog2(WBQ_DEPTH+1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock
  - `reset` in 1: asynchronous reset, active-high
- Flush and issue:
  - `flush_` in 1: synchronous flush, active-low
  - `issue_e_` in 1: issue valid, active-low
  - `issue_op` in 4: operation code
  - `issue_trap` in 1: enable overflow exception for ADD/SUB
  - `issue_rob_id` in ROB: ROB tag
  - `issue_rd` in RD: destination tag
  - `data1`, `data2` in DATA: operands
  - `issue_ready` out 1: a credit is available
- Writeback:
  - `wb_req_` out 1: queue head valid, active-low
  - `wb_ack_` in 1: arbiter accepts head, active-low
  - `wb_rob_id` out ROB: head ROB tag
  - `wb_rd` out RD: head destination tag
  - `wb_data` out DATA: head result
  - `wb_exp_` out 1: head exception, active-low
- Status:
  - `inflight` out CNT: pipeline entries plus queue entries
  - `busy` out 1: `inflight` != 0

## Operation
- Ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed) and 6 SLTU: result 1 or 0, zero-extended
  - 7 SLL, 8 SRL, 9 SRA: shift amount = `data2`[$clog2(DATA)-1:0]
  - 10 PASS: result = `data2`
  - 11..15 illegal: result 0, `wb_exp_`=0
- Overflow: with ADD/SUB and `issue_trap`=1, signed overflow sets exp (0). The wrapped result is still written.
- Result computation: combinational from the issue-cycle inputs, registered into stage 1. The tag, exp and valid bits travel with the data through `STAGES`-1 intermediate registers.
- Queue write: the last register stage is the queue write. An entry leaving the pipeline is written into the queue on that edge.
- Credits:
  - `issue_ready` = (`inflight` < `WBQ_DEPTH`), registered-state only, with no same-cycle pop lookahead.
  - Issue with `issue_ready`=0 is ignored: no state change, no entry created.
  - The credit rule guarantees the queue never overflows, so the pipeline never stalls.
- Handshake:
  - The head is presented while `wb_req_`=0.
  - A pop occurs on an edge where `wb_req_`=0 and `wb_ack_`=0.
  - All `wb_*` outputs are stable while `wb_req_`=0 and no ack occurs.
  - `wb_ack_`=0 while `wb_req_`=1 is ignored.
- Flush:
  - `flush_`=0 at an edge clears all pipeline valids, empties the queue and zeroes `inflight`.
  - Flush has priority over a same-cycle issue, pop and pipeline write; those are all discarded.
- Simultaneous events:
  - A same-edge issue, pipeline write and pop are all honoured.
  - `inflight` changes by (+1 on issue) and (-1 on pop).
- Queue implementation: circular buffer with wrap-around read/write pointers. The empty or full state comes from the occupancy counter, never from pointer equality alone.
- Reset values:
  - `wb_req_`=1, `wb_exp_`=1
  - `wb_data`=0, `wb_rd`=0, `wb_rob_id`=0
  - `inflight`=0, `busy`=0, `issue_ready`=1
  - All valids and pointers cleared.
- Reset mid-operation: all in-flight results are lost with no writeback.

## Timing
- Latency:
  - Issue sampled at the end of cycle N; with an empty queue, `wb_req_`=0 and the head outputs are valid in cycle N+`STAGES`.
  - If the queue is non-empty, the entry waits behind older entries in FIFO order.
- Throughput: one issue per cycle sustained when `WBQ_DEPTH` >= `STAGES`+1 and the arbiter acks every cycle.
- Ack timing: an ack in cycle M makes the next entry visible in cycle M+1. If the queue becomes empty, `wb_req_`=1 in M+1.
- `issue_ready` latency: it falls the cycle after `inflight` reaches `WBQ_DEPTH` and rises the cycle after a pop or flush reduces it.
- Flush latency: `flush_`=0 in cycle F gives `wb_req_`=1, `inflight`=0, `issue_ready`=1 in cycle F+1.
- Output sourcing: all outputs are driven from registers, with no combinational input-to-output paths.

## Test plan
- Latency and sign extension: `STAGES`=2, issue ADD 5+7, rd=3, rob=9 in cycle 0 with `wb_ack_`=0 held -> cycle 2 shows `wb_req_`=0, `wb_data`=12, `wb_rd`=3, `wb_rob_id`=9, `wb_exp_`=1. Next, issue SRA 0x80000000 by 4 -> `wb_data`=0xF8000000.
- Overflow trap: ADD 0x7FFFFFFF+1 with `issue_trap`=1 -> `wb_data`=0x80000000, `wb_exp_`=0. The same op with trap=0 gives `wb_exp_`=1. Op 12 gives `wb_data`=0, `wb_exp_`=0.
- Backpressure and credits: `WBQ_DEPTH`=4, `wb_ack_`=1, issue every cycle -> exactly 4 accepted and `issue_ready`=0 with `inflight`=4; a 5th issue is ignored. Ack once -> one pop, `issue_ready`=1 the next cycle, and the queue drains in issue order across a pointer wrap.
- Simultaneous events: at `inflight`=3, same-edge issue, pipeline write and pop -> `inflight` stays 3 and no entry is lost or duplicated.
- Flush priority: 3 entries queued and 1 in the pipeline, then `flush_`=0 with a same-cycle issue and ack -> the next cycle has `wb_req_`=1 and `inflight`=0, and no result from before the flush ever appears.
- Asynchronous reset: assert `reset` mid-cycle with entries queued -> all outputs immediately take their reset values, and the first post-reset issue completes normally.
